// File: rtl/prf_wr_arbiter_pkg.sv
// Shared types and helpers for the PRF write-bank arbiter: register/data widths,
// the buffered write request payload and the bank/row split of a physical register.
package prf_wr_arbiter_pkg;

  localparam int unsigned XLEN                     = 32;
  localparam int unsigned LOG_PR_COUNT             = 7;
  localparam int unsigned PRF_WR_COUNT             = 8;
  localparam int unsigned PRF_BANK_COUNT           = 4;
  localparam int unsigned LOG_PRF_BANK_COUNT       = 2;
  localparam int unsigned PRF_WR_INPUT_BUFFER_SIZE = 2;

  typedef logic [XLEN-1:0]                            xlen_t;
  typedef logic [LOG_PR_COUNT-1:0]                    pr_t;
  typedef logic [LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] upper_pr_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0]              pr_bank_t;
  typedef logic [$clog2(PRF_WR_COUNT)-1:0]            prf_wr_port_t;

  typedef struct packed {
    pr_t   pr;
    xlen_t data;
  } prf_wr_req_t;

  // Row within the bank: everything above the bank-select bits.
  function automatic upper_pr_t upper_pr_bits(input pr_t pr);
    return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
  endfunction

  function automatic pr_bank_t pr_bank_bits(input pr_t pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

endpackage

// File: rtl/prf_wr_arbiter_input_buffer.sv
// Per-source write request FIFO. ready and head_valid are registered from the
// next count, so a full buffer that dequeues still reports not-ready that cycle.
module prf_wr_input_buffer
  import prf_wr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = PRF_WR_INPUT_BUFFER_SIZE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enq,
  input  prf_wr_req_t enq_data,
  input  logic        deq,
  output logic        head_valid,
  output prf_wr_req_t head,
  output logic        ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  prf_wr_req_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             do_enq;
  logic             do_deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_enq = enq && ready;
  assign do_deq = deq && head_valid;

  always_comb begin
    count_n = count;
    if (do_enq && !do_deq)      count_n = count + CNT_W'(1);
    else if (!do_enq && do_deq) count_n = count - CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready      <= 1'b1;
      head_valid <= 1'b0;
    end else begin
      if (do_enq) wr_ptr <= ptr_inc(wr_ptr);
      if (do_deq) rd_ptr <= ptr_inc(rd_ptr);
      count      <= count_n;
      ready      <= (count_n < CNT_W'(DEPTH));
      head_valid <= (count_n != '0);
    end
  end

  // Payload storage needs no reset: head_valid qualifies every read.
  always_ff @(posedge CLK) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/prf_wr_arbiter.sv
// Shares the four PRF write banks among eight writeback sources: per-source FIFOs,
// per-bank round-robin over FIFO heads, registered bank write with winning port.
module prf_wr_arbiter
  import prf_wr_arbiter_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PRF_WR_COUNT-1:0]   wr_valid_by_port,
  input  pr_t                       wr_pr_by_port [PRF_WR_COUNT],
  input  xlen_t                     wr_data_by_port [PRF_WR_COUNT],
  output logic [PRF_WR_COUNT-1:0]   wr_ready_by_port,
  output logic [PRF_BANK_COUNT-1:0] bank_wr_valid_by_bank,
  output upper_pr_t                 bank_wr_upper_pr_by_bank [PRF_BANK_COUNT],
  output xlen_t                     bank_wr_data_by_bank [PRF_BANK_COUNT],
  output prf_wr_port_t              bank_wr_port_by_bank [PRF_BANK_COUNT]
);

  logic [PRF_WR_COUNT-1:0]   enq;
  logic [PRF_WR_COUNT-1:0]   deq;
  logic [PRF_WR_COUNT-1:0]   head_valid;
  prf_wr_req_t               head [PRF_WR_COUNT];
  prf_wr_port_t              rr_ptr [PRF_BANK_COUNT];
  logic [PRF_BANK_COUNT-1:0] win_found;
  prf_wr_port_t              win_idx [PRF_BANK_COUNT];

  assign enq = wr_valid_by_port & wr_ready_by_port;

  for (genvar p = 0; p < PRF_WR_COUNT; p++) begin : g_port
    prf_wr_req_t enq_req;
    assign enq_req = '{pr: wr_pr_by_port[p], data: wr_data_by_port[p]};

    prf_wr_input_buffer #(
      .DEPTH(PRF_WR_INPUT_BUFFER_SIZE)
    ) u_buf (
      .CLK       (CLK),
      .RST       (RST),
      .enq       (enq[p]),
      .enq_data  (enq_req),
      .deq       (deq[p]),
      .head_valid(head_valid[p]),
      .head      (head[p]),
      .ready     (wr_ready_by_port[p])
    );
  end

  // Per bank: first candidate head at or after rr_ptr, wrapping over the port space.
  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    logic [PRF_WR_COUNT-1:0] cand;
    logic                    found;
    prf_wr_port_t            idx;

    always_comb begin
      cand = '0;
      for (int p = 0; p < PRF_WR_COUNT; p++) begin
        cand[p] = head_valid[p] && (pr_bank_bits(head[p].pr) == pr_bank_t'(b));
      end
    end

    always_comb begin
      found = 1'b0;
      idx   = rr_ptr[b];
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (!found && cand[rr_ptr[b] + prf_wr_port_t'(i)]) begin
          found = 1'b1;
          idx   = rr_ptr[b] + prf_wr_port_t'(i);
        end
      end
    end

    assign win_found[b] = found;
    assign win_idx[b]   = idx;
  end

  // A head maps to exactly one bank, so each port sees at most one grant.
  always_comb begin
    deq = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      if (win_found[b]) deq[win_idx[b]] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bank_wr_valid_by_bank <= '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        rr_ptr[b]                   <= '0;
        bank_wr_upper_pr_by_bank[b] <= '0;
        bank_wr_data_by_bank[b]     <= '0;
        bank_wr_port_by_bank[b]     <= '0;
      end
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        bank_wr_valid_by_bank[b] <= win_found[b];
        if (win_found[b]) begin
          rr_ptr[b]                   <= win_idx[b] + prf_wr_port_t'(1);
          bank_wr_upper_pr_by_bank[b] <= upper_pr_bits(head[win_idx[b]].pr);
          bank_wr_data_by_bank[b]     <= head[win_idx[b]].data;
          bank_wr_port_by_bank[b]     <= win_idx[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// Bench for prf_wr_arbiter: per-(bank,port) scoreboard checked on every bank write,
// plus directed scenario tasks for latency, round-robin order, HOL blocking and reset.
module tb_prf_wr_arbiter;
  import prf_wr_arbiter_pkg::*;

  typedef struct packed {
    upper_pr_t upper;
    xlen_t     data;
  } sb_t;

  logic                      CLK = 1'b0;
  logic                      RST = 1'b1;
  logic [PRF_WR_COUNT-1:0]   wr_valid_by_port;
  pr_t                       wr_pr_by_port [PRF_WR_COUNT];
  xlen_t                     wr_data_by_port [PRF_WR_COUNT];
  logic [PRF_WR_COUNT-1:0]   wr_ready_by_port;
  logic [PRF_BANK_COUNT-1:0] bank_wr_valid_by_bank;
  upper_pr_t                 bank_wr_upper_pr_by_bank [PRF_BANK_COUNT];
  xlen_t                     bank_wr_data_by_bank [PRF_BANK_COUNT];
  prf_wr_port_t              bank_wr_port_by_bank [PRF_BANK_COUNT];

  sb_t exp_q [PRF_BANK_COUNT*PRF_WR_COUNT][$];
  int  errors = 0;
  int  checks = 0;

  always #5 CLK = ~CLK;

  prf_wr_arbiter dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .wr_valid_by_port        (wr_valid_by_port),
    .wr_pr_by_port           (wr_pr_by_port),
    .wr_data_by_port         (wr_data_by_port),
    .wr_ready_by_port        (wr_ready_by_port),
    .bank_wr_valid_by_bank   (bank_wr_valid_by_bank),
    .bank_wr_upper_pr_by_bank(bank_wr_upper_pr_by_bank),
    .bank_wr_data_by_bank    (bank_wr_data_by_bank),
    .bank_wr_port_by_bank    (bank_wr_port_by_bank)
  );

  // Every bank write must match the oldest outstanding request of that port for that bank.
  always @(negedge CLK) begin
    sb_t got;
    sb_t want;
    int  k;
    if (!RST) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (bank_wr_valid_by_bank[b]) begin
          k   = b * PRF_WR_COUNT + int'(bank_wr_port_by_bank[b]);
          got = '{upper: bank_wr_upper_pr_by_bank[b], data: bank_wr_data_by_bank[b]};
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL sb_spurious bank=%0d port=%0d got upper=%h data=%h, required no write",
                     b, bank_wr_port_by_bank[b], got.upper, got.data);
          end else begin
            want = exp_q[k].pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL sb_data bank=%0d port=%0d got upper=%h data=%h, required upper=%h data=%h",
                       b, bank_wr_port_by_bank[b], got.upper, got.data, want.upper, want.data);
            end
          end
        end
      end
    end
  end

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < PRF_BANK_COUNT*PRF_WR_COUNT; k++) n += exp_q[k].size();
    return n;
  endfunction

  task automatic clear_sb();
    for (int k = 0; k < PRF_BANK_COUNT*PRF_WR_COUNT; k++) exp_q[k].delete();
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    #1;
    wr_valid_by_port = '0;
  endtask

  // Drive a request; it is expected at the bank only if ready is high this cycle.
  task automatic set_req(input int p, input pr_t pr, input xlen_t d);
    logic [1:0] bank;
    logic [4:0] row;
    bank = pr[1:0];
    row  = pr[6:2];
    wr_valid_by_port[p] = 1'b1;
    wr_pr_by_port[p]    = pr;
    wr_data_by_port[p]  = d;
    if (wr_ready_by_port[p]) exp_q[int'(bank)*PRF_WR_COUNT + p].push_back('{upper: row, data: d});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pending() != 0; i++) step();
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    wr_valid_by_port = '0;
    clear_sb();
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (wr_ready_by_port !== 8'hFF) begin
      errors++; $display("FAIL reset_ready got=%h required=ff", wr_ready_by_port);
    end
    checks++;
    if (bank_wr_valid_by_bank !== 4'h0) begin
      errors++; $display("FAIL reset_valid got=%h required=0", bank_wr_valid_by_bank);
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      checks++;
      if (bank_wr_upper_pr_by_bank[b] !== '0 || bank_wr_data_by_bank[b] !== '0 ||
          bank_wr_port_by_bank[b] !== '0) begin
        errors++;
        $display("FAIL reset_fields bank=%0d got upper=%h data=%h port=%0d required all 0", b,
                 bank_wr_upper_pr_by_bank[b], bank_wr_data_by_bank[b], bank_wr_port_by_bank[b]);
      end
    end
    RST = 1'b0;
    step();
    checks++;
    if (wr_ready_by_port !== 8'hFF) begin
      errors++; $display("FAIL post_reset_ready got=%h required=ff", wr_ready_by_port);
    end
  endtask

  task automatic test_single_write();
    set_req(3, 7'h25, 32'h0000_DEAD);
    step();
    checks++;
    if (bank_wr_valid_by_bank !== 4'h0) begin
      errors++; $display("FAIL single_early got=%h required=0", bank_wr_valid_by_bank);
    end
    step();
    checks++;
    if (bank_wr_valid_by_bank !== 4'b0010) begin
      errors++; $display("FAIL single_valid got=%b required=0010", bank_wr_valid_by_bank);
    end
    checks++;
    if (bank_wr_upper_pr_by_bank[1] !== 5'h09 || bank_wr_data_by_bank[1] !== 32'h0000_DEAD ||
        bank_wr_port_by_bank[1] !== 3'd3) begin
      errors++;
      $display("FAIL single_fields got upper=%h data=%h port=%0d required upper=09 data=0000dead port=3",
               bank_wr_upper_pr_by_bank[1], bank_wr_data_by_bank[1], bank_wr_port_by_bank[1]);
    end
    step();
    checks++;
    if (bank_wr_valid_by_bank !== 4'h0) begin
      errors++; $display("FAIL single_after got=%h required=0", bank_wr_valid_by_bank);
    end
  endtask

  task automatic test_contention();
    int         ports [3]     = '{0, 2, 5};
    int         exp_order [6] = '{0, 2, 5, 0, 2, 5};
    int         seq [$];
    logic [7:0] saw_busy = '0;
    int         got;
    for (int c = 0; c < 8; c++) begin
      foreach (ports[i]) begin
        if (!wr_ready_by_port[ports[i]]) saw_busy[ports[i]] = 1'b1;
        set_req(ports[i], pr_t'(4 * (c + 1)), xlen_t'(32'hC000_0000 + ports[i] * 256 + c));
      end
      step();
      if (bank_wr_valid_by_bank[0]) seq.push_back(int'(bank_wr_port_by_bank[0]));
    end
    for (int i = 0; i < 40 && pending() != 0; i++) begin
      step();
      if (bank_wr_valid_by_bank[0]) seq.push_back(int'(bank_wr_port_by_bank[0]));
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < seq.size()) ? seq[i] : -1;
      checks++;
      if (got != exp_order[i]) begin
        errors++; $display("FAIL contention_order idx=%0d got port=%0d required=%0d", i, got, exp_order[i]);
      end
    end
    foreach (ports[i]) begin
      checks++;
      if (saw_busy[ports[i]] !== 1'b1) begin
        errors++; $display("FAIL contention_ready_drop port=%0d got never-busy required busy seen", ports[i]);
      end
    end
    checks++;
    if (pending() != 0) begin
      errors++; $display("FAIL contention_lost got pending=%0d required=0", pending());
    end
  endtask

  task automatic test_parallel_banks();
    for (int p = 0; p < 4; p++) set_req(p, pr_t'(4 + p), xlen_t'(32'h5A00_0000 + p));
    step();
    step();
    checks++;
    if (bank_wr_valid_by_bank !== 4'hF) begin
      errors++; $display("FAIL parallel_valid got=%b required=1111", bank_wr_valid_by_bank);
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      checks++;
      if (int'(bank_wr_port_by_bank[b]) != b || bank_wr_upper_pr_by_bank[b] !== 5'h01) begin
        errors++;
        $display("FAIL parallel_fields bank=%0d got port=%0d upper=%h required port=%0d upper=01",
                 b, bank_wr_port_by_bank[b], bank_wr_upper_pr_by_bank[b], b);
      end
    end
    drain();
  endtask

  task automatic test_hol_blocking();
    set_req(1, 7'h0A, 32'hA1A1_0001);
    set_req(4, 7'h12, 32'hB4B4_0001);
    step();
    set_req(1, 7'h0F, 32'hA1A1_0002);
    set_req(4, 7'h16, 32'hB4B4_0002);
    step();
    checks++;
    if (bank_wr_valid_by_bank[2] !== 1'b1 || bank_wr_port_by_bank[2] !== 3'd4 || bank_wr_valid_by_bank[3] !== 1'b0) begin
      errors++;
      $display("FAIL hol_first got v2=%b port2=%0d v3=%b required v2=1 port2=4 v3=0",
               bank_wr_valid_by_bank[2], bank_wr_port_by_bank[2], bank_wr_valid_by_bank[3]);
    end
    set_req(4, 7'h1A, 32'hB4B4_0003);
    step();
    checks++;
    if (bank_wr_valid_by_bank[2] !== 1'b1 || bank_wr_port_by_bank[2] !== 3'd1 || bank_wr_valid_by_bank[3] !== 1'b0) begin
      errors++;
      $display("FAIL hol_second got v2=%b port2=%0d v3=%b required v2=1 port2=1 v3=0",
               bank_wr_valid_by_bank[2], bank_wr_port_by_bank[2], bank_wr_valid_by_bank[3]);
    end
    set_req(4, 7'h1E, 32'hB4B4_0004);
    step();
    checks++;
    if (bank_wr_valid_by_bank[3] !== 1'b1 || bank_wr_port_by_bank[3] !== 3'd1) begin
      errors++;
      $display("FAIL hol_third got v3=%b port3=%0d required v3=1 port3=1",
               bank_wr_valid_by_bank[3], bank_wr_port_by_bank[3]);
    end
    drain();
    checks++;
    if (pending() != 0) begin
      errors++; $display("FAIL hol_lost got pending=%0d required=0", pending());
    end
  endtask

  task automatic test_full_fifo();
    apply_reset();
    set_req(1, 7'h04, 32'hC1C1_0001);
    set_req(6, 7'h08, 32'hF6F6_0001);
    step();
    checks++;
    if (wr_ready_by_port[6] !== 1'b1) begin
      errors++; $display("FAIL full_ready_one got=%b required=1", wr_ready_by_port[6]);
    end
    set_req(1, 7'h0C, 32'hC1C1_0002);
    set_req(6, 7'h10, 32'hF6F6_0002);
    step();
    checks++;
    if (wr_ready_by_port[6] !== 1'b0) begin
      errors++; $display("FAIL full_ready_while_granted got=%b required=0", wr_ready_by_port[6]);
    end
    set_req(6, 7'h14, 32'hF6F6_0003);
    step();
    checks++;
    if (bank_wr_valid_by_bank[0] !== 1'b1 || bank_wr_port_by_bank[0] !== 3'd6) begin
      errors++;
      $display("FAIL full_grant got v0=%b port0=%0d required v0=1 port0=6",
               bank_wr_valid_by_bank[0], bank_wr_port_by_bank[0]);
    end
    checks++;
    if (wr_ready_by_port[6] !== 1'b1) begin
      errors++; $display("FAIL full_ready_after got=%b required=1", wr_ready_by_port[6]);
    end
    set_req(6, 7'h14, 32'hF6F6_0003);
    step();
    drain();
    checks++;
    if (pending() != 0) begin
      errors++; $display("FAIL full_lost got pending=%0d required=0", pending());
    end
  endtask

  task automatic test_reset_midflight();
    for (int p = 0; p < 5; p++) set_req(p, pr_t'(4 * (p + 1)), xlen_t'(32'hDD00_0000 + p));
    step();
    RST = 1'b1;
    clear_sb();
    #1;
    checks++;
    if (wr_ready_by_port !== 8'hFF || bank_wr_valid_by_bank !== 4'h0) begin
      errors++;
      $display("FAIL midreset_during got ready=%h valid=%h required ready=ff valid=0",
               wr_ready_by_port, bank_wr_valid_by_bank);
    end
    step();
    step();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bank_wr_valid_by_bank !== 4'h0 || wr_ready_by_port !== 8'hFF) begin
        errors++;
        $display("FAIL midreset_after cycle=%0d got valid=%h ready=%h required valid=0 ready=ff",
                 i, bank_wr_valid_by_bank, wr_ready_by_port);
      end
    end
    set_req(7, 7'h20, 32'h7777_0001);
    set_req(0, 7'h24, 32'h0000_0001);
    step();
    step();
    checks++;
    if (bank_wr_valid_by_bank[0] !== 1'b1 || bank_wr_port_by_bank[0] !== 3'd0) begin
      errors++;
      $display("FAIL midreset_rr_first got v0=%b port0=%0d required v0=1 port0=0",
               bank_wr_valid_by_bank[0], bank_wr_port_by_bank[0]);
    end
    step();
    checks++;
    if (bank_wr_valid_by_bank[0] !== 1'b1 || bank_wr_port_by_bank[0] !== 3'd7) begin
      errors++;
      $display("FAIL midreset_rr_second got v0=%b port0=%0d required v0=1 port0=7",
               bank_wr_valid_by_bank[0], bank_wr_port_by_bank[0]);
    end
    set_req(7, 7'h28, 32'h7777_0002);
    step();
    step();
    checks++;
    if (bank_wr_valid_by_bank[0] !== 1'b1 || bank_wr_port_by_bank[0] !== 3'd7) begin
      errors++;
      $display("FAIL midreset_port7_idle0 got v0=%b port0=%0d required v0=1 port0=7",
               bank_wr_valid_by_bank[0], bank_wr_port_by_bank[0]);
    end
    drain();
    checks++;
    if (pending() != 0) begin
      errors++; $display("FAIL midreset_lost got pending=%0d required=0", pending());
    end
  endtask

  initial begin
    wr_valid_by_port = '0;
    for (int p = 0; p < PRF_WR_COUNT; p++) begin
      wr_pr_by_port[p]   = '0;
      wr_data_by_port[p] = '0;
    end
    test_reset();
    test_single_write();
    test_contention();
    test_parallel_banks();
    test_hol_blocking();
    test_full_fifo();
    test_reset_midflight();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prf_wr_arbiter.md
# prf_wr_arbiter

Shares the physical register file's four write banks among the eight PRF writeback sources (WR_BUF, LDU bank 0, LDU bank 1, ALU Reg-Reg, MDU, ALU Reg-Imm, BRU, SYSU). Each source has a small input buffer. Every cycle, each bank picks at most one buffer head that targets it, using per-bank round-robin. The winner is driven as a registered bank write, and the winning port index is driven alongside it for writeback/wakeup broadcast. The block sits between the execution-unit writeback outputs and the banked PRF storage.

## Interface
- PRF_WR_COUNT, 8, number of requester ports
- PRF_BANK_COUNT, 4, number of PRF write banks; bank = pr[LOG_PRF_BANK_COUNT-1:0]
- PRF_WR_INPUT_BUFFER_SIZE, 2, FIFO depth per requester port
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset
- wr_valid_by_port  in  [PRF_WR_COUNT]  write request valid
- wr_pr_by_port  in  [PRF_WR_COUNT] x pr_t  destination physical register
- wr_data_by_port  in  [PRF_WR_COUNT] x xlen_t  write data
- wr_ready_by_port  out  [PRF_WR_COUNT]  buffer can accept this cycle
- bank_wr_valid_by_bank  out  [PRF_BANK_COUNT]  bank write this cycle
- bank_wr_upper_pr_by_bank  out  [PRF_BANK_COUNT] x upper_pr_t  row within the bank
- bank_wr_data_by_bank  out  [PRF_BANK_COUNT] x xlen_t  write data
- bank_wr_port_by_bank  out  [PRF_BANK_COUNT] x 3b  winning port index

## Operation
- Enqueue: a request is accepted when wr_valid & wr_ready. It is appended to that port's FIFO as {pr, data}.
- wr_ready = (count < PRF_WR_INPUT_BUFFER_SIZE), computed from registered count only. A full buffer that dequeues in the same cycle still shows ready=0.
- Only the FIFO head of each port is eligible; no reordering within a port. Head-of-line blocking is accepted behaviour.
- Per bank b, the candidate set is the ports with a non-empty FIFO whose head pr bank equals b.
- Per-bank round-robin pointer rr_ptr[b] (3b): grant the first candidate at or after rr_ptr[b], scanning upward and wrapping 7→0.
- On a grant, rr_ptr[b] ← winner+1 mod 8. With no candidates, rr_ptr[b] holds.
- A granted head is dequeued at the end of the cycle.
- Each port's head belongs to exactly one bank, so a port receives at most one grant per cycle. Different ports may win different banks in the same cycle, giving up to 4 writes per cycle.
- The grant registers the bank output: valid=1, upper_pr=upper_pr_bits(head.pr), data, and port=winner. With no grant, valid ← 0 and the other output fields hold.
- Simultaneous enqueue and dequeue on the same port: count is unchanged and FIFO order is preserved. When the FIFO was empty the new entry is not granted this cycle (no bypass).
- FIFO pointers and count wrap modulo PRF_WR_INPUT_BUFFER_SIZE; count is 0..SIZE inclusive.

## Timing
- Request accepted in cycle N → becomes head no earlier than N+1 → bank_wr_valid no earlier than N+2 (2-cycle minimum latency).
- The PRF accepts every bank write; there is no bank backpressure.
- Reset, asynchronous and at any time, including mid-operation:
  - all FIFOs emptied and counts 0
  - all wr_ready=1 from the first cycle after RST deasserts; while RST is high, wr_ready reads 1 but nothing is enqueued
  - all rr_ptr=0
  - bank_wr_valid=0; upper_pr, data and port all 0
  - in-flight entries are discarded

## Structure
- Add to corep:
  - typedef struct packed {pr_t pr; xlen_t data;} prf_wr_req_t
  - typedef logic [$clog2(PRF_WR_COUNT)-1:0] prf_wr_port_t
- Reuse corep PRF_WR_COUNT, PRF_BANK_COUNT, PRF_WR_INPUT_BUFFER_SIZE, upper_pr_bits and pr_bank_bits.
- Sub-module prf_wr_input_buffer: a parameterized FIFO of prf_wr_req_t with enq/deq, head_valid, head and ready. It is instantiated once per port.
- Per-bank round-robin grant logic stays inline, as a generate loop over banks.

## Test plan
- Single write: port 3 writes pr=0x25 (bank 1, upper 0x09), data=0xDEAD in cycle 0 → bank_wr_valid[1]=1, upper_pr=0x09, data=0xDEAD, port=3 in cycle 2; other banks invalid.
- Contention: ports 0, 2 and 5 all write bank 0 every cycle after reset → grants in order 0,2,5,0,2,5.
  - Each port sees ready drop while its FIFO holds 2 entries; no request is lost or duplicated.
- Parallel banks: ports 0–3 write pr=4, 5, 6, 7 (banks 0–3) in the same cycle → all four bank_wr_valid asserted together 2 cycles later.
- Head-of-line blocking: port 1 enqueues bank-2 then bank-3 while port 4 keeps bank 2 busy → port 1's bank-3 entry is not written until its bank-2 entry wins.
- Full FIFO: fill port 6 with 2 entries while bank blocked, then grant and enqueue in the same cycle → ready stays 0 that cycle; the next request is accepted one cycle later.
- Reset mid-flight: assert RST with 5 entries buffered across ports → no bank_wr_valid afterward, all wr_ready=1 and rr_ptr=0.
  - A fresh bank-0 request from port 7 is then granted ahead of port 0 only if port 0 is idle.
